// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit-drain state encoding.
// Reused by uart_rx/uart_tx and the transmit FIFO.
package uart_pkg;

    localparam int UART_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count and full/empty flags.
// Read data is the combinational head entry (first-word fall-through).
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding uart_tx: valid/ready push side, one-at-a-time drain
// with a tx_busy handshake and a timeout in case busy never rises.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ACK_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_W-1:0]      wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [UART_W-1:0]      tx_in,
    output logic                   tx_en,
    input  logic                   tx_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

    tx_state_t         state;
    logic [ACK_W-1:0]  ack_cnt;
    logic [UART_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic              pop;

    assign wr_ready = !full;
    assign pop      = (state == IDLE) && !empty && !tx_busy;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_valid),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
        end
    end

    // tx_in is held after the pop so uart_tx may sample it any time later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ack_cnt <= '0;
            tx_in   <= '0;
            tx_en   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_en <= 1'b0;
                    if (pop) begin
                        tx_in   <= rd_data;
                        tx_en   <= 1'b1;
                        ack_cnt <= '0;
                        state   <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    tx_en <= 1'b0;
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        state <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    tx_en <= 1'b0;
                    if (!tx_busy) state <= IDLE;
                end
                default: begin
                    tx_en <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural tx_busy stub.
// Expected values are hand-derived from the drain timing.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] tx_in;
    logic       tx_en;
    logic       tx_busy;
    logic [4:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    logic busy_force = 1'b0;
    logic auto_en    = 1'b0;
    int   busy_len   = 0;
    int   bcnt       = 0;
    int   dbl        = 0;
    logic prev_en    = 1'b0;
    int   peak       = 0;
    logic [7:0] q_log [$];
    logic [7:0] sb    [$];

    always #5 clk = ~clk;

    assign tx_busy = busy_force | (bcnt != 0);

    uart_tx_fifo #(
        .DEPTH      (16),
        .ACK_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .tx_in    (tx_in),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .count    (count),
        .overflow (overflow)
    );

    // Stub transmitter: busy for busy_len cycles after each accepted tx_en.
    always @(posedge clk) begin
        if (auto_en && tx_en === 1'b1) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
        if (tx_en === 1'b1) q_log.push_back(tx_in);
        if (tx_en === 1'b1 && prev_en === 1'b1) dbl <= dbl + 1;
        prev_en <= tx_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n, input int bound, input string tag);
        int k;
        k = 0;
        while (!(q_log.size() == n && count == 0) && k < bound) begin
            if (int'(count) > peak) peak = int'(count);
            step();
            k++;
        end
        chk(tag, 32'(k < bound), 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_tx_in", 32'(tx_in), 32'h00);
        step();
        reset = 1'b1;
        step();

        // single byte: write edge, then pop edge
        auto_en  = 1'b1;
        busy_len = 10;
        push(8'hA5);
        chk("single_cnt1", 32'(count), 32'd1);
        chk("single_en0", 32'(tx_en), 32'd0);
        step();
        chk("single_en1", 32'(tx_en), 32'd1);
        chk("single_data", 32'(tx_in), 32'hA5);
        chk("single_cnt0", 32'(count), 32'd0);
        step();
        chk("single_pulse", 32'(tx_en), 32'd0);
        wait_drain(1, 50, "single_drain");
        repeat (14) step();
        chk("single_once", 32'(q_log.size()), 32'd1);
        chk("single_hold", 32'(tx_in), 32'hA5);

        // burst of five
        q_log.delete();
        busy_len = 6;
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
            if (int'(count) > peak) peak = int'(count);
        end
        wait_drain(5, 200, "burst_drain");
        for (int i = 0; i < 5; i++)
            chk($sformatf("burst_b%0d", i), 32'(q_log[i]), 32'(i + 1));
        chk("burst_peak", 32'(peak >= 4), 32'd1);

        // fill to 16, 17th dropped
        repeat (10) step();
        q_log.delete();
        auto_en    = 1'b0;
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        chk("full_cnt", 32'(count), 32'd16);
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_ovf0", 32'(overflow), 32'd0);
        push(8'hEE);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd16);
        chk("ovf_none_sent", 32'(q_log.size()), 32'd0);
        busy_force = 1'b0;
        auto_en    = 1'b1;
        busy_len   = 3;
        wait_drain(16, 600, "full_drain");
        for (int i = 0; i < 16; i++)
            chk($sformatf("full_b%0d", i), 32'(q_log[i]), 32'h10 + 32'(i));
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // ack timeout: busy never rises, 4 cycles in WAIT_BUSY
        repeat (10) step();
        q_log.delete();
        auto_en = 1'b0;
        push(8'h3C);
        push(8'h3D);
        chk("to_en1", 32'(tx_en), 32'd1);
        chk("to_data1", 32'(tx_in), 32'h3C);
        chk("to_cnt1", 32'(count), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("to_wait%0d", i), 32'(tx_en), 32'd0);
        end
        chk("to_cnt_hold", 32'(count), 32'd1);
        step();
        chk("to_en2", 32'(tx_en), 32'd1);
        chk("to_data2", 32'(tx_in), 32'h3D);
        chk("to_cnt0", 32'(count), 32'd0);
        wait_drain(2, 20, "to_drain");

        // simultaneous push/pop at count=1, 40 bytes across pointer wrap
        repeat (6) step();
        q_log.delete();
        for (int i = 0; i < 40; i++) begin
            sb.push_back(8'(i * 37 + 5));
            push(8'(i * 37 + 5));
            if (i > 0) begin
                chk($sformatf("pp_cnt%0d", i), 32'(count), 32'd1);
                chk($sformatf("pp_en%0d", i), 32'(tx_en), 32'd1);
                repeat (4) step();
            end
        end
        wait_drain(40, 30, "pp_drain");
        for (int i = 0; i < 40; i++)
            chk($sformatf("pp_b%0d", i), 32'(q_log[i]), 32'(sb[i]));
        chk("single_cycle_en", 32'(dbl), 32'd0);

        // async reset with three bytes queued
        busy_force = 1'b1;
        push(8'h71);
        push(8'h72);
        push(8'h73);
        chk("mid_cnt3", 32'(count), 32'd3);
        reset = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(count), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd1);
        chk("mid_rst_en", 32'(tx_en), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
